// File: rtl/thor2022_alu_wbq.sv
// ALU writeback queue: 4-entry FIFO draining primary and secondary results to the register file.
// Define THOR2022_ALU_WBQ_FWD_EN to add the q_ra/q_hit/q_val forwarding search.
module thor2022_alu_wbq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_v,
  output logic        i_rdy,
  input  logic [5:0]  i_tgt,
  input  logic [63:0] i_res,
  input  logic        i_t2v,
  input  logic [5:0]  i_t2tgt,
  input  logic [63:0] i_t2,
  output logic        o_wr,
  output logic [5:0]  o_wa,
  output logic [63:0] o_wd,
  input  logic        o_ack,
  output logic [2:0]  o_cnt,
  output logic        o_empty
`ifdef THOR2022_ALU_WBQ_FWD_EN
  ,
  input  logic [5:0]  q_ra,
  output logic        q_hit,
  output logic [63:0] q_val
`endif
);

  typedef enum logic [1:0] {IDLE, PRI, SEC} state_e;

  typedef struct packed {
    logic [5:0]  tgt;
    logic [63:0] res;
    logic        t2v;
    logic [5:0]  t2tgt;
    logic [63:0] t2;
    logic        pdone;
  } entry_t;

  entry_t      q_q [4];
  entry_t      q_d [4];
  state_e      state_q, state_d;
  logic [1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  cnt_q, cnt_d;
  entry_t      head, new_e;
  logic        push, pop, set_pd;

  always_comb begin
    head  = q_q[rd_q];
    i_rdy = (cnt_q != 3'd4);

    new_e.tgt   = i_tgt;
    new_e.res   = i_res;
    new_e.t2v   = i_t2v & (i_t2tgt != 6'd0);
    new_e.t2tgt = i_t2tgt;
    new_e.t2    = i_t2;
    new_e.pdone = (i_tgt == 6'd0);
    // An entry with nothing to write is accepted and dropped.
    push = i_v & i_rdy & ((i_tgt != 6'd0) | new_e.t2v);

    o_wr   = 1'b0;
    o_wa   = 6'd0;
    o_wd   = 64'd0;
    pop    = 1'b0;
    set_pd = 1'b0;
    case (state_q)
      PRI: begin
        o_wr = 1'b1;
        o_wa = head.tgt;
        o_wd = head.res;
        if (o_ack) begin
          if (head.t2v) set_pd = 1'b1;
          else          pop    = 1'b1;
        end
      end
      SEC: begin
        o_wr = 1'b1;
        o_wa = head.t2tgt;
        o_wd = head.t2;
        pop  = o_ack;
      end
      default: ;
    endcase

    q_d  = q_q;
    rd_d = rd_q;
    wr_d = wr_q;
    if (set_pd) q_d[rd_q].pdone = 1'b1;
    if (pop) rd_d = rd_q + 2'd1;
    if (push) begin
      q_d[wr_q] = new_e;
      wr_d      = wr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    // Next state follows the head entry as it will stand after this edge.
    if (cnt_d == 3'd0)         state_d = IDLE;
    else if (q_d[rd_d].pdone)  state_d = SEC;
    else                       state_d = PRI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 2'd0;
      wr_q    <= 2'd0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 4; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) q_q[i] <= q_d[i];
    end
  end

  assign o_cnt   = cnt_q;
  assign o_empty = (cnt_q == 3'd0);

`ifdef THOR2022_ALU_WBQ_FWD_EN
  logic [1:0] fidx;
  entry_t     fe;

  // Walk oldest to youngest so later matches override; t2 checked after primary.
  always_comb begin
    q_hit = 1'b0;
    q_val = 64'd0;
    fidx  = 2'd0;
    fe    = '0;
    for (int i = 0; i < 4; i++) begin
      fidx = rd_q + i[1:0];
      fe   = q_q[fidx];
      if ((i < int'(cnt_q)) && (q_ra != 6'd0)) begin
        if (!fe.pdone && (fe.tgt == q_ra)) begin
          q_hit = 1'b1;
          q_val = fe.res;
        end
        if (fe.t2v && (fe.t2tgt == q_ra)) begin
          q_hit = 1'b1;
          q_val = fe.t2;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_thor2022_alu_wbq.sv
// Testbench for thor2022_alu_wbq: directed scenarios plus randomized traffic against a beat-list model.
module tb_thor2022_alu_wbq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_v;
  logic        i_rdy;
  logic [5:0]  i_tgt;
  logic [63:0] i_res;
  logic        i_t2v;
  logic [5:0]  i_t2tgt;
  logic [63:0] i_t2;
  logic        o_wr;
  logic [5:0]  o_wa;
  logic [63:0] o_wd;
  logic        o_ack;
  logic [2:0]  o_cnt;
  logic        o_empty;
`ifdef THOR2022_ALU_WBQ_FWD_EN
  logic [5:0]  q_ra;
  logic        q_hit;
  logic [63:0] q_val;
`endif

  int checks = 0;
  int errors = 0;

  thor2022_alu_wbq dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_rdy(i_rdy),
    .i_tgt(i_tgt), .i_res(i_res), .i_t2v(i_t2v), .i_t2tgt(i_t2tgt), .i_t2(i_t2),
    .o_wr(o_wr), .o_wa(o_wa), .o_wd(o_wd), .o_ack(o_ack),
    .o_cnt(o_cnt), .o_empty(o_empty)
`ifdef THOR2022_ALU_WBQ_FWD_EN
    , .q_ra(q_ra), .q_hit(q_hit), .q_val(q_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] tgt, input logic [63:0] res,
                        input logic t2v, input logic [5:0] t2tgt, input logic [63:0] t2);
    i_v = v; i_tgt = tgt; i_res = res; i_t2v = t2v; i_t2tgt = t2tgt; i_t2 = t2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    o_ack = 1'b0;
    set_in(1'b1, 6'd12, 64'hdead, 1'b1, 6'd13, 64'hbeef);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({o_wr, o_cnt, o_empty, i_rdy} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got wr=%0b cnt=%0d empty=%0b rdy=%0b expected wr=0 cnt=0 empty=1 rdy=1",
               o_wr, o_cnt, o_empty, i_rdy);
    end
    tick();
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_ignores_iv: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
`ifdef THOR2022_ALU_WBQ_FWD_EN
    q_ra = 6'd12;
    #1;
    checks++;
    if (q_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_qhit: got %0b expected 0", q_hit);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    o_ack = 1'b1;
    set_in(1'b1, 6'd5, 64'h1234, 1'b0, 6'd0, 64'd0);
    tick();
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({o_wr, o_wa, o_wd, o_cnt} !== {1'b1, 6'd5, 64'h1234, 3'd1}) begin
      errors++;
      $display("FAIL single_beat: got wr=%0b wa=%0d wd=%0h cnt=%0d expected wr=1 wa=5 wd=1234 cnt=1",
               o_wr, o_wa, o_wd, o_cnt);
    end
    tick();
    checks++;
    if ({o_wr, o_cnt, o_empty} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_drain: got wr=%0b cnt=%0d empty=%0b expected wr=0 cnt=0 empty=1",
               o_wr, o_cnt, o_empty);
    end
  endtask

  task automatic test_dual();
    do_reset();
    o_ack = 1'b1;
    set_in(1'b1, 6'd3, 64'hAA, 1'b1, 6'd4, 64'h1);
    tick();
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({o_wr, o_wa, o_wd, o_cnt} !== {1'b1, 6'd3, 64'hAA, 3'd1}) begin
      errors++;
      $display("FAIL dual_pri: got wr=%0b wa=%0d wd=%0h cnt=%0d expected wr=1 wa=3 wd=aa cnt=1",
               o_wr, o_wa, o_wd, o_cnt);
    end
    tick();
    checks++;
    if ({o_wr, o_wa, o_wd, o_cnt} !== {1'b1, 6'd4, 64'h1, 3'd1}) begin
      errors++;
      $display("FAIL dual_sec: got wr=%0b wa=%0d wd=%0h cnt=%0d expected wr=1 wa=4 wd=1 cnt=1",
               o_wr, o_wa, o_wd, o_cnt);
    end
    tick();
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL dual_drain: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
  endtask

  task automatic test_full();
    do_reset();
    o_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 6'(10 + i), 64'(256 + i), 1'b0, 6'd0, 64'd0);
      checks++;
      if (i_rdy !== (i < 4)) begin
        errors++;
        $display("FAIL full_rdy%0d: got %0b expected %0b", i, i_rdy, (i < 4));
      end
      tick();
    end
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({o_cnt, i_rdy, o_wr, o_wa} !== {3'd4, 1'b0, 1'b1, 6'd10}) begin
      errors++;
      $display("FAIL full_hold: got cnt=%0d rdy=%0b wr=%0b wa=%0d expected cnt=4 rdy=0 wr=1 wa=10",
               o_cnt, i_rdy, o_wr, o_wa);
    end
    o_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_wr, o_wa, o_wd} !== {1'b1, 6'(10 + k), 64'(256 + k)}) begin
        errors++;
        $display("FAIL full_order%0d: got wr=%0b wa=%0d wd=%0h expected wr=1 wa=%0d wd=%0h",
                 k, o_wr, o_wa, o_wd, 10 + k, 256 + k);
      end
      tick();
      if (k == 0) begin
        checks++;
        if ({i_rdy, o_cnt} !== {1'b1, 3'd3}) begin
          errors++;
          $display("FAIL full_rdy_return: got rdy=%0b cnt=%0d expected rdy=1 cnt=3", i_rdy, o_cnt);
        end
      end
    end
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL full_drain: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
  endtask

  task automatic test_r0();
    do_reset();
    o_ack = 1'b1;
    set_in(1'b1, 6'd0, 64'h77, 1'b0, 6'd7, 64'h9);
    checks++;
    if (i_rdy !== 1'b1) begin
      errors++;
      $display("FAIL r0_rdy: got %0b expected 1", i_rdy);
    end
    tick();
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL r0_drop: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
    set_in(1'b1, 6'd0, 64'h77, 1'b1, 6'd7, 64'h9);
    tick();
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({o_wr, o_wa, o_wd} !== {1'b1, 6'd7, 64'h9}) begin
      errors++;
      $display("FAIL r0_sec_only: got wr=%0b wa=%0d wd=%0h expected wr=1 wa=7 wd=9", o_wr, o_wa, o_wd);
    end
    tick();
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL r0_drain: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    o_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 6'(20 + k), 64'(4096 + k), 1'b0, 6'd0, 64'd0);
      tick();
      checks++;
      if ({o_wr, o_wa, o_wd, o_cnt} !== {1'b1, 6'(20 + k), 64'(4096 + k), 3'd1}) begin
        errors++;
        $display("FAIL b2b_%0d: got wr=%0b wa=%0d wd=%0h cnt=%0d expected wr=1 wa=%0d wd=%0h cnt=1",
                 k, o_wr, o_wa, o_wd, o_cnt, 20 + k, 4096 + k);
      end
    end
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    tick();
    checks++;
    if ({o_wr, o_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL b2b_drain: got wr=%0b cnt=%0d expected wr=0 cnt=0", o_wr, o_cnt);
    end
  endtask

  task automatic test_reset_mid_sec();
    do_reset();
    o_ack = 1'b1;
    set_in(1'b1, 6'd3, 64'hAA, 1'b1, 6'd4, 64'h55);
    tick();
    set_in(1'b1, 6'd6, 64'h66, 1'b0, 6'd0, 64'd0);
    tick();
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    o_ack = 1'b0;
    checks++;
    if ({o_wr, o_wa, o_cnt} !== {1'b1, 6'd4, 3'd2}) begin
      errors++;
      $display("FAIL midsec_setup: got wr=%0b wa=%0d cnt=%0d expected wr=1 wa=4 cnt=2", o_wr, o_wa, o_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o_ack = 1'b1;
    checks++;
    if ({o_wr, o_cnt, o_empty} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL midsec_reset: got wr=%0b cnt=%0d empty=%0b expected wr=0 cnt=0 empty=1",
               o_wr, o_cnt, o_empty);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_wr !== 1'b0) begin
        errors++;
        $display("FAIL midsec_nobeat%0d: got wr=%0b expected 0", k, o_wr);
      end
    end
  endtask

`ifdef THOR2022_ALU_WBQ_FWD_EN
  task automatic test_fwd();
    do_reset();
    o_ack = 1'b0;
    q_ra  = 6'd9;
    set_in(1'b1, 6'd9, 64'h10, 1'b0, 6'd0, 64'd0);
    tick();
    checks++;
    if ({q_hit, q_val} !== {1'b1, 64'h10}) begin
      errors++;
      $display("FAIL fwd_first: got hit=%0b val=%0h expected hit=1 val=10", q_hit, q_val);
    end
    set_in(1'b1, 6'd9, 64'h20, 1'b0, 6'd0, 64'd0);
    tick();
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({q_hit, q_val} !== {1'b1, 64'h20}) begin
      errors++;
      $display("FAIL fwd_youngest: got hit=%0b val=%0h expected hit=1 val=20", q_hit, q_val);
    end
    o_ack = 1'b1;
    tick();
    tick();
    checks++;
    if (q_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_retired: got hit=%0b expected 0", q_hit);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0]  exp_wa [$];
    logic [63:0] exp_wd [$];
    int          ent_n  [$];
    logic        v, t2v, ack;
    logic [5:0]  tgt, t2tgt;
    logic [63:0] res, t2;
    int          n;
    do_reset();
    for (int it = 0; it < 600; it++) begin
`ifdef THOR2022_ALU_WBQ_FWD_EN
      q_ra = 6'($urandom_range(0, 7));
      #1;
      begin
        logic        eh;
        logic [63:0] ev;
        eh = 1'b0;
        ev = 64'd0;
        for (int b = 0; b < exp_wa.size(); b++)
          if (exp_wa[b] == q_ra) begin eh = 1'b1; ev = exp_wd[b]; end
        checks++;
        if ({q_hit, q_val} !== {eh, ev}) begin
          errors++;
          $display("FAIL rnd_fwd@%0d: got hit=%0b val=%0h expected hit=%0b val=%0h",
                   it, q_hit, q_val, eh, ev);
        end
      end
`endif
      checks++;
      if ({o_cnt, o_empty, i_rdy} !== {3'(ent_n.size()), ent_n.size() == 0, ent_n.size() < 4}) begin
        errors++;
        $display("FAIL rnd_cnt@%0d: got cnt=%0d empty=%0b rdy=%0b expected cnt=%0d",
                 it, o_cnt, o_empty, i_rdy, ent_n.size());
      end
      checks++;
      if (exp_wa.size() == 0) begin
        if (o_wr !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle@%0d: got wr=%0b expected 0", it, o_wr);
        end
      end else if ({o_wr, o_wa, o_wd} !== {1'b1, exp_wa[0], exp_wd[0]}) begin
        errors++;
        $display("FAIL rnd_beat@%0d: got wr=%0b wa=%0d wd=%0h expected wr=1 wa=%0d wd=%0h",
                 it, o_wr, o_wa, o_wd, exp_wa[0], exp_wd[0]);
      end

      v     = (it < 150) ? 1'b1 : ($urandom_range(0, 9) < 6);
      ack   = (it < 150) ? 1'b1 : ($urandom_range(0, 9) < 5);
      tgt   = 6'($urandom_range(0, 7));
      t2v   = $urandom_range(0, 1);
      t2tgt = 6'($urandom_range(0, 7));
      res   = {$urandom, $urandom};
      t2    = {$urandom, $urandom};
      set_in(v, tgt, res, t2v, t2tgt, t2);
      o_ack = ack;

      n = ent_n.size();
      if (ack && (n > 0)) begin
        void'(exp_wa.pop_front());
        void'(exp_wd.pop_front());
        ent_n[0] = ent_n[0] - 1;
        if (ent_n[0] == 0) void'(ent_n.pop_front());
      end
      if (v && (n < 4)) begin
        n = 0;
        if (tgt != 0) begin exp_wa.push_back(tgt); exp_wd.push_back(res); n++; end
        if (t2v && (t2tgt != 0)) begin exp_wa.push_back(t2tgt); exp_wd.push_back(t2); n++; end
        if (n > 0) ent_n.push_back(n);
      end
      tick();
    end
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    o_ack = 1'b0;
    set_in(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
`ifdef THOR2022_ALU_WBQ_FWD_EN
    q_ra = 6'd0;
`endif
    test_reset();
    test_single();
    test_dual();
    test_full();
    test_r0();
    test_back_to_back();
    test_reset_mid_sec();
`ifdef THOR2022_ALU_WBQ_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thor2022_alu_wbq.md
THOR2022_ALU_WBQ -- requirements
Module: thor2022_alu_wbq

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: i_v  in  1  ALU result valid.
REQ-004 SHALL have ports: i_rdy  out  1  queue can accept (occupancy < 4).
REQ-005 SHALL have ports: i_tgt  in  6  primary target register; i_res  in  64  primary result (ALU res).
REQ-006 SHALL have ports: i_t2v  in  1  secondary result present; i_t2tgt  in  6  secondary target; i_t2  in  64  secondary result (ALU res_t2: carry or shifted-out bits).
REQ-007 SHALL have ports: o_wr  out  1  register-file write request; o_wa  out  6  write address; o_wd  out  64  write data; o_ack  in  1  write accepted this cycle.
REQ-008 SHALL have ports: o_cnt  out  3  entries held (0..4); o_empty  out  1  o_cnt==0.
REQ-009 SHALL have forwarding ports, present only with the macro in REQ-026: q_ra  in  6  query register; q_hit  out  1  pending write to q_ra; q_val  out  64  its value.

Function
REQ-010 SHALL hold a 4-entry FIFO; each entry: tgt, res, t2v, t2tgt, t2, pdone (primary beat written).
REQ-011 SHALL enqueue on i_v & i_rdy; i_rdy SHALL be 0 whenever o_cnt==4, even if a dequeue happens that cycle.
REQ-012 SHALL accept but not enqueue a transfer with i_tgt==0 and (i_t2v==0 or i_t2tgt==0); register 0 is never written.
REQ-013 SHALL clear t2v on enqueue when i_t2tgt==0; SHALL mark pdone=1 on enqueue when i_tgt==0 and t2 remains valid.
REQ-014 SHALL use 2-bit read/write pointers wrapping 3->0 and a 3-bit count; simultaneous enqueue and dequeue leaves o_cnt unchanged.
REQ-015 SHALL present entries in arrival order; earliest o_wr for an entry enqueued in cycle N is cycle N+1 (no input-to-output bypass).
REQ-016 SHALL implement state machine IDLE, PRI, SEC over the head entry:
REQ-017 IDLE: o_wr=0; go PRI if head pdone==0, SEC if head pdone==1, stay if empty.
REQ-018 PRI: o_wr=1, o_wa=tgt, o_wd=res; on o_ack set pdone; then SEC if t2v, else pop head and go PRI/SEC/IDLE per next head.
REQ-019 SEC: o_wr=1, o_wa=t2tgt, o_wd=t2; on o_ack pop head and select next state as in REQ-017.
REQ-020 SHALL hold o_wa/o_wd stable while o_wr=1 and o_ack=0; at most one beat retires per cycle.
REQ-021 Back-to-back: with o_ack held 1, SHALL issue one write per cycle with no idle cycle between entries.
REQ-022 o_cnt SHALL decrement only on the final beat of an entry.

Reset
REQ-023 On rst=1 at a clock edge SHALL set state IDLE, pointers 0, count 0, all pdone/t2v 0; next cycle o_wr=0, o_cnt=0, o_empty=1, i_rdy=1.
REQ-024 rst mid-operation SHALL discard all queued and partially-written entries; no further beat of a discarded entry is issued.
REQ-025 While rst=1, i_v SHALL be ignored; q_hit SHALL read 0 the cycle after reset.

Configuration
REQ-026 Macro THOR2022_ALU_WBQ_FWD_EN: when defined, q_ra/q_hit/q_val exist; q_hit/q_val are combinational from current queue contents, excluding register 0 and already-written beats; youngest match wins, and within one entry t2 outranks primary.
REQ-027 Without THOR2022_ALU_WBQ_FWD_EN, the forwarding ports and search logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Single entry: tgt=5,res=0x1234,t2v=0, o_ack=1 -> one beat cycle N+1, o_wa=5,o_wd=0x1234, o_cnt back to 0.
REQ-029 Dual beat: tgt=3,res=0xAA,t2v=1,t2tgt=4,t2=0x1, o_ack=1 -> beats (3,0xAA) then (4,0x1) on consecutive cycles.
REQ-030 Full/backpressure: o_ack=0, 5 transfers -> i_rdy=0 after 4th, o_cnt=4; release o_ack -> FIFO order, i_rdy returns 1 after first pop.
REQ-031 r0: tgt=0,t2v=0 -> accepted, o_cnt stays 0; tgt=0,t2tgt=7,t2=0x9 -> only beat (7,0x9).
REQ-032 Reset mid-SEC: assert rst while o_wa=t2tgt -> next cycle o_wr=0, o_cnt=0, no SEC beat later.
REQ-033 FWD_EN: queue (9,0x10) then (9,0x20), o_ack=0, q_ra=9 -> q_hit=1, q_val=0x20; after both retire q_hit=0.
